// File: rtl/fifo_stream_reader_if.sv
// Reader-side bundle: FIFO read port, valid/ready output stream and word counter.
// master = the stream reader itself, slave = the FIFO/sink environment around it.
interface fifo_stream_reader_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             en;
   logic             fifo_empty;
   logic             fifo_wr_active;
   logic [WIDTH-1:0] fifo_data;
   logic             fifo_rd;
   logic             m_valid;
   logic [WIDTH-1:0] m_data;
   logic             m_ready;
   logic [CNT_W-1:0] rd_count;

   modport master (
      input  en, fifo_empty, fifo_wr_active, fifo_data, m_ready,
      output fifo_rd, m_valid, m_data, rd_count
   );

   modport slave (
      output en, fifo_empty, fifo_wr_active, fifo_data, m_ready,
      input  fifo_rd, m_valid, m_data, rd_count
   );
endinterface

// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the 16x8 synchronous FIFO. Issues rd strobes ahead of
// demand, absorbs the FIFO's one-cycle read latency in a 3-entry skid buffer and
// re-presents the words as a valid/ready stream. m_ready never reaches fifo_rd:
// reads are throttled purely on buffered + in-flight words.
module fifo_stream_reader #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic                clk,
   input logic                rst,
   fifo_stream_reader_if.master bus
);

   logic [WIDTH-1:0] buf_q [0:2];
   logic [1:0]       head;
   logic [1:0]       tail;
   logic [1:0]       occ;
   logic             pending;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       fill;
   logic             issued;
   logic             pop;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Words already committed to the buffer: landed plus the one still in flight.
   assign fill        = 3'(occ) + 3'(pending);
   assign bus.fifo_rd = !rst && bus.en && !bus.fifo_empty && (fill < 3'd3);
   // A write in the same cycle wins inside the FIFO, so that read never happened.
   assign issued      = bus.fifo_rd && !bus.fifo_wr_active;
   assign bus.m_valid = (occ != 2'd0);
   assign bus.m_data  = buf_q[head];
   assign pop         = bus.m_valid && bus.m_ready;
   assign bus.rd_count = cnt;

   // Buffer storage: no reset needed, occ gates whether an entry is visible.
   always_ff @(posedge clk) begin
      if (pending) buf_q[tail] <= bus.fifo_data;
   end

   // Pointers, occupancy, in-flight flag and delivered-word counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         head    <= 2'd0;
         tail    <= 2'd0;
         occ     <= 2'd0;
         pending <= 1'b0;
         cnt     <= '0;
      end else begin
         pending <= issued;
         if (pending) tail <= ptr_inc(tail);
         if (pop) begin
            head <= ptr_inc(head);
            cnt  <= cnt + CNT_W'(1);
         end
         occ <= occ + 2'(pending) - 2'(pop);
      end
   end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue-based model of the 16x8 FIFO drives the
// DUT, and a scoreboard of words read from that FIFO (in read order) predicts
// fifo_rd, m_valid, m_data and rd_count every cycle.
module tb_fifo_stream_reader;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifo_stream_reader_if #(.WIDTH(8), .CNT_W(16)) bus ();

   fifo_stream_reader #(.WIDTH(8), .CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0] fq[$];     // FIFO contents
   logic [7:0] sb[$];     // words read from FIFO, not yet delivered
   logic       pend;      // a read was accepted last cycle (data not landed yet)
   logic [15:0] dcnt;
   logic       armed = 1'b0;
   logic       hold  = 1'b0;
   logic [7:0] hold_data;
   logic       wr;
   logic [7:0] wr_data;

   int cyc_n = 0;
   int n_acc, n_hs, n_rd_hi, n_gap, first_acc, first_val, first_hs, last_hs, first_data;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc_n);
      end
   endtask

   task automatic set_flags();
      bus.fifo_empty     = (fq.size() == 0);
      bus.fifo_wr_active = wr && (fq.size() < 16);
   endtask

   task automatic clr_stats();
      n_acc = 0; n_hs = 0; n_rd_hi = 0; n_gap = 0;
      first_acc = -1; first_val = -1; first_hs = -1; last_hs = -1; first_data = -1;
   endtask

   // One clock: check outputs before the edge, then advance FIFO and scoreboard.
   task automatic cyc();
      logic rd_now, wr_act, acc_now, exp_valid, hs;
      set_flags();
      wr_act = bus.fifo_wr_active;
      #1;
      exp_valid = (sb.size() - int'(pend)) > 0;
      if (armed) begin
         chk("fifo_rd", 32'(bus.fifo_rd),
             32'(!rst && bus.en && fq.size() != 0 && sb.size() < 3));
         chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
         chk("rd_count", 32'(bus.rd_count), 32'(dcnt));
         if (hold) chk("m_data_hold", 32'(bus.m_data), 32'(hold_data));
         if (exp_valid && bus.m_ready) chk("m_data", 32'(bus.m_data), 32'(sb[0]));
      end
      rd_now  = bus.fifo_rd;
      acc_now = rd_now && !wr_act && fq.size() > 0;
      hs      = exp_valid && bus.m_ready && !rst;
      if (armed) begin
         n_acc   += int'(acc_now);
         n_rd_hi += int'(rd_now);
         n_gap   += int'(!bus.m_valid);
         if (acc_now && first_acc < 0) first_acc = cyc_n;
         if (bus.m_valid && first_val < 0) first_val = cyc_n;
         if (bus.m_valid && bus.m_ready && !rst) begin
            if (first_hs < 0) begin first_hs = cyc_n; first_data = int'(bus.m_data); end
            last_hs = cyc_n;
            n_hs++;
         end
      end
      hold      = armed && bus.m_valid && !bus.m_ready && !rst;
      hold_data = bus.m_data;
      @(posedge clk);
      #1;
      if (wr_act) fq.push_back(wr_data);
      else if (rd_now && fq.size() > 0) bus.fifo_data = fq.pop_front();
      if (rst) begin
         sb.delete(); pend = 1'b0; dcnt = '0; armed = 1'b1;
      end else begin
         if (hs) begin void'(sb.pop_front()); dcnt++; end
         if (acc_now) sb.push_back(bus.fifo_data);
         pend = acc_now;
      end
      cyc_n++;
      set_flags();
      @(negedge clk);
   endtask

   task automatic do_reset();
      fq.delete();
      rst = 1'b1; bus.en = 1'b0; bus.m_ready = 1'b0; wr = 1'b0;
      cyc();
      rst = 1'b0;
      clr_stats();
   endtask

   task automatic preload(input int n, input logic [7:0] base);
      bus.en = 1'b0; bus.m_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         wr = 1'b1; wr_data = base + 8'(i);
         cyc();
      end
      wr = 1'b0;
   endtask

   initial begin
      int n_coll;
      rst = 1'b1; wr = 1'b0; wr_data = '0; pend = 1'b0; dcnt = '0;
      bus.en = 1'b0; bus.m_ready = 1'b0; bus.fifo_data = '0;
      set_flags();
      clr_stats();

      // Short burst: latency, back-to-back delivery, drain.
      do_reset();
      chk("reset_valid", 32'(bus.m_valid), 0);
      chk("reset_count", 32'(bus.rd_count), 0);
      wr = 1'b1; wr_data = 8'h11; cyc();
      wr_data = 8'h22; cyc();
      wr_data = 8'h33; cyc();
      wr = 1'b0; clr_stats();
      bus.en = 1'b1; bus.m_ready = 1'b1;
      for (int i = 0; i < 12; i++) cyc();
      chk("latency", 32'(first_val - first_acc), 2);
      chk("burst_hs", 32'(n_hs), 3);
      chk("burst_span", 32'(last_hs - first_hs), 2);
      chk("burst_first", 32'(first_data), 32'h11);
      chk("burst_count", 32'(bus.rd_count), 3);
      chk("burst_idle", 32'(bus.m_valid), 0);

      // Backpressure with a full FIFO, then release.
      do_reset();
      preload(16, 8'h00);
      clr_stats();
      bus.en = 1'b1; bus.m_ready = 1'b0;
      for (int i = 0; i < 10; i++) cyc();
      chk("bp_reads", 32'(n_acc), 3);
      chk("bp_rd_low", 32'(bus.fifo_rd), 0);
      chk("bp_head", 32'(bus.m_data), 0);
      clr_stats();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 40 && n_hs < 16; i++) cyc();
      chk("bp_hs", 32'(n_hs), 16);
      chk("bp_gaps", 32'(n_gap), 0);
      chk("bp_count", 32'(bus.rd_count), 16);

      // Writes colliding with reads: dropped reads must not lose or duplicate.
      do_reset();
      preload(6, 8'h40);
      clr_stats();
      n_coll = 0;
      bus.en = 1'b1; bus.m_ready = 1'b1;
      for (int i = 0; i < 30; i++) begin
         wr = bus.fifo_rd && (n_coll == 0 || $urandom_range(0, 1) == 1);
         wr_data = 8'h80 + 8'(n_coll);
         if (wr) n_coll++;
         cyc();
      end
      wr = 1'b0;
      for (int i = 0; i < 40 && n_hs < 6 + n_coll; i++) cyc();
      chk("coll_hs", 32'(n_hs), 32'(6 + n_coll));
      chk("coll_first", 32'(first_data), 32'h40);

      // m_ready toggling over 8 words.
      do_reset();
      preload(8, 8'hA0);
      clr_stats();
      bus.en = 1'b1;
      for (int i = 0; i < 40 && n_hs < 8; i++) begin
         bus.m_ready = (i % 2 == 0);
         cyc();
      end
      chk("toggle_hs", 32'(n_hs), 8);
      chk("toggle_count", 32'(bus.rd_count), 8);

      // Drop en with one word landed and one in flight.
      do_reset();
      preload(4, 8'hC0);
      clr_stats();
      bus.en = 1'b1; bus.m_ready = 1'b0;
      for (int i = 0; i < 10 && n_acc < 2; i++) cyc();
      bus.en = 1'b0; bus.m_ready = 1'b1;
      clr_stats();
      for (int i = 0; i < 6; i++) cyc();
      chk("en_off_hs", 32'(n_hs), 2);
      chk("en_off_rd", 32'(n_rd_hi), 0);
      chk("en_off_idle", 32'(bus.m_valid), 0);
      chk("en_off_first", 32'(first_data), 32'hC0);

      // Reset with two words buffered and one in flight.
      do_reset();
      preload(6, 8'h60);
      clr_stats();
      bus.en = 1'b1; bus.m_ready = 1'b0;
      for (int i = 0; i < 10 && n_acc < 3; i++) cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(bus.m_valid), 0);
      chk("mid_rst_count", 32'(bus.rd_count), 0);
      clr_stats();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 20 && n_hs < 3; i++) cyc();
      chk("mid_rst_hs", 32'(n_hs), 3);
      chk("mid_rst_first", 32'(first_data), 32'h63);

      // Random traffic against the scoreboard.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         bus.en      = ($urandom_range(0, 7) != 0);
         bus.m_ready = ($urandom_range(0, 1) == 1);
         wr          = ($urandom_range(0, 2) == 0);
         wr_data     = 8'($urandom);
         cyc();
      end
      rst = 1'b0; wr = 1'b0; bus.en = 1'b1; bus.m_ready = 1'b1;
      for (int i = 0; i < 40; i++) cyc();
      chk("rand_drained", 32'(bus.m_valid), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
